race_state_controller: RTL and testbench

- Race-level FSM that produces the 3-bit `state` consumed by the physics engine and the display/HUD path.
- Sequences the race: idle, settings entry, start countdown, racing, pause and finish.
- Owns the race timer and lap counter; finish is triggered by lap-crossing pulses from the track/checkpoint logic.
- Sits directly upstream of the physics engine, in parallel with the operation encoder.

---
 rtl/race_pkg.sv | 23 ++
 rtl/race_state_controller_if.sv | 25 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/race_state_controller.sv | 134 +++++++++++++
 tb/tb_race_state_controller.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/race_pkg.sv
// Race sequencing constants shared by the race FSM, physics engine and HUD.
// State encodings are fixed; 2 and 7 are unused.
package race_pkg;

  localparam int STATE_W = 3;
  localparam int CD_W    = 3;
  localparam int LAP_W   = 3;
  localparam int TICKS_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } race_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/race_state_controller_if.sv
// Control pulses in, race status out, between the race FSM and its
// neighbours (input debouncers, physics engine, HUD).
interface race_state_controller_if;
  import race_pkg::*;

  logic               start_pulse;
  logic               pause_pulse;
  logic               lap_pulse;
  logic [STATE_W-1:0] state;
  logic [CD_W-1:0]    countdown;
  logic [TICKS_W-1:0] race_ticks;
  logic [LAP_W-1:0]   lap;
  logic               finish_pulse;

  modport master (
    output start_pulse, pause_pulse, lap_pulse,
    input  state, countdown, race_ticks, lap, finish_pulse
  );

  modport slave (
    input  start_pulse, pause_pulse, lap_pulse,
    output state, countdown, race_ticks, lap, finish_pulse
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running clk divider; tick is high on the last cycle of each period.
// Holding en low freezes the phase so a paused race resumes seamlessly.
module tick_prescaler
  import race_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_w(CLKS_PER_TICK);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/race_state_controller.sv
// Race-level FSM: settings, countdown, racing, pause and finish, plus the
// race timer and lap counter feeding the physics engine and HUD.
module race_state_controller
  import race_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 1_000_000,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned COUNTDOWN_SEC = 3,
  parameter int unsigned LAP_TOTAL     = 3
) (
  input logic clk,
  input logic rst_n,
  race_state_controller_if.slave bus
);

  localparam int SW = cnt_w(TICKS_PER_SEC);
  localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);

  race_state_e        state_q, state_d;
  logic [CD_W-1:0]    countdown_q, countdown_d;
  logic [TICKS_W-1:0] ticks_q, ticks_d;
  logic [LAP_W-1:0]   lap_q, lap_d;
  logic [SW-1:0]      sec_q, sec_d;
  logic               fin_q, fin_d;
  logic               en, clr, tick;

  tick_prescaler #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      countdown_q <= '0;
      ticks_q     <= '0;
      lap_q       <= '0;
      sec_q       <= '0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      ticks_q     <= ticks_d;
      lap_q       <= lap_d;
      sec_q       <= sec_d;
      fin_q       <= fin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    ticks_d     = ticks_q;
    lap_d       = lap_q;
    sec_d       = sec_q;
    fin_d       = 1'b0;
    en          = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_pulse) state_d = SETTING;
      end
      SETTING: begin
        if (bus.start_pulse) begin
          state_d     = COUNTDOWN;
          countdown_d = CD_W'(COUNTDOWN_SEC);
          clr         = 1'b1;
          sec_d       = '0;
          ticks_d     = '0;
          lap_d       = '0;
        end
      end
      COUNTDOWN: begin
        en = 1'b1;
        if (tick) begin
          if (sec_q == SEC_LAST) begin
            sec_d = '0;
            if (countdown_q == 3'd1) begin
              state_d     = RACING;
              countdown_d = '0;
            end else begin
              countdown_d = countdown_q - 3'd1;
            end
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end
      end
      RACING: begin
        en = 1'b1;
        if (tick && ticks_q != 16'hFFFF) ticks_d = ticks_q + 16'd1;
        if (bus.lap_pulse) begin
          lap_d = lap_q + 3'd1;
          // final lap beats a coincident pause
          if (lap_q + 3'd1 == LAP_W'(LAP_TOTAL)) begin
            state_d = FINISH;
            fin_d   = 1'b1;
          end else if (bus.pause_pulse) begin
            state_d = PAUSE;
          end
        end else if (bus.pause_pulse) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.pause_pulse) state_d = RACING;
      end
      FINISH: begin
        if (bus.start_pulse) begin
          state_d     = IDLE;
          countdown_d = '0;
          ticks_d     = '0;
          lap_d       = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        countdown_d = '0;
      end
    endcase
  end

  assign bus.state        = state_q;
  assign bus.countdown    = countdown_q;
  assign bus.race_ticks   = ticks_q;
  assign bus.lap          = lap_q;
  assign bus.finish_pulse = fin_q;

endmodule

// File: tb/tb_race_state_controller.sv
// Randomised and directed bench for race_state_controller against a
// cycle-count reference model; a second fast instance covers saturation.
module tb_race_state_controller;

  localparam int CPT = 4;
  localparam int TPS = 2;
  localparam int CDS = 3;
  localparam int LT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  always #5 clk = ~clk;

  race_state_controller_if bus ();
  race_state_controller_if bus2 ();

  race_state_controller #(
    .CLKS_PER_TICK(CPT),
    .TICKS_PER_SEC(TPS),
    .COUNTDOWN_SEC(CDS),
    .LAP_TOTAL    (LT)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  race_state_controller #(
    .CLKS_PER_TICK(1),
    .TICKS_PER_SEC(2),
    .COUNTDOWN_SEC(1),
    .LAP_TOTAL    (7)
  ) u_sat (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (bus2)
  );

  int checks = 0;
  int errors = 0;

  // model: state plus cycles spent counting down / racing
  int m_state, m_elapsed, m_rcyc, m_lap;
  bit m_fin;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_rcyc = 0; m_lap = 0; m_fin = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit l);
    int prev = m_state;
    case (m_state)
      0: if (s) m_state = 1;
      1: if (s) begin
        m_state = 3; m_elapsed = 0; m_rcyc = 0; m_lap = 0;
      end
      3: begin
        m_elapsed++;
        if (m_elapsed == CDS * TPS * CPT) m_state = 4;
      end
      4: begin
        m_rcyc++;
        if (l) begin
          m_lap++;
          if (m_lap == LT) m_state = 6;
          else if (p) m_state = 5;
        end else if (p) begin
          m_state = 5;
        end
      end
      5: if (p) m_state = 4;
      6: if (s) begin
        m_state = 0; m_lap = 0; m_rcyc = 0;
      end
      default: m_state = 0;
    endcase
    m_fin = (m_state == 6) && (prev != 6);
  endtask

  function automatic int exp_cd();
    return (m_state == 3) ? CDS - m_elapsed / (CPT * TPS) : 0;
  endfunction

  function automatic int exp_ticks();
    int t = m_rcyc / CPT;
    return (t > 65535) ? 65535 : t;
  endfunction

  task automatic compare_all();
    check("state", int'(bus.state), m_state);
    check("countdown", int'(bus.countdown), exp_cd());
    check("race_ticks", int'(bus.race_ticks), exp_ticks());
    check("lap", int'(bus.lap), m_lap);
    check("finish_pulse", int'(bus.finish_pulse), int'(m_fin));
  endtask

  task automatic step(input bit s, input bit p, input bit l);
    @(negedge clk);
    bus.start_pulse = s;
    bus.pause_pulse = p;
    bus.lap_pulse   = l;
    @(posedge clk);
    model_step(s, p, l);
    #1;
    compare_all();
    bus.start_pulse = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
  endtask

  task automatic run_to_racing(input string tag);
    int n = 0;
    while (int'(bus.state) != 4 && n < 40) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      n++;
    end
    check(tag, n, CDS * TPS * CPT);
  endtask

  initial begin
    bus.start_pulse = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
    bus2.start_pulse = 1'b0;
    bus2.pause_pulse = 1'b0;
    bus2.lap_pulse   = 1'b0;
    model_reset();
    fork
      begin : main_seq
        int t0, fz, n;
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(0, 1, 1);
        step(1, 0, 0);
        step(0, 1, 1);
        step(1, 0, 0);
        run_to_racing("cd_len");
        check("ticks_at_race", int'(bus.race_ticks), 0);

        repeat (40) step(0, 0, 0);
        check("timer40", int'(bus.race_ticks), 10);

        n = 0;
        while (m_rcyc % CPT != 1 && n < 8) begin
          step(0, 0, 0);
          n++;
        end
        step(0, 1, 0);
        check("paused", int'(bus.state), 5);
        t0 = int'(bus.race_ticks);
        repeat (100) step(0, 0, 0);
        check("pause_hold", int'(bus.race_ticks), t0);
        step(0, 1, 0);
        check("resume_same", int'(bus.race_ticks), t0);
        step(0, 0, 0);
        check("resume_plus1", int'(bus.race_ticks), t0);
        step(0, 0, 0);
        check("resume_plus2", int'(bus.race_ticks), t0 + 1);

        step(0, 0, 1);
        check("lap1", int'(bus.lap), 1);
        repeat (11) step(0, 0, 0);
        step(0, 0, 1);
        check("fin_state", int'(bus.state), 6);
        check("fin_lap", int'(bus.lap), 2);
        check("fin_pulse", int'(bus.finish_pulse), 1);
        fz = int'(bus.race_ticks);
        step(0, 0, 0);
        check("fin_pulse_once", int'(bus.finish_pulse), 0);
        repeat (6) step(0, 1, 1);
        check("fin_frozen", int'(bus.race_ticks), fz);
        step(1, 0, 0);
        check("back_idle", int'(bus.state), 0);
        check("idle_ticks", int'(bus.race_ticks), 0);
        check("idle_lap", int'(bus.lap), 0);

        step(1, 0, 0);
        step(1, 0, 0);
        run_to_racing("cd_len2");
        repeat (3) step(0, 0, 0);
        step(0, 1, 1);
        check("lap_pause_lap", int'(bus.lap), 1);
        check("lap_pause_state", int'(bus.state), 5);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 1);
        check("final_pause_state", int'(bus.state), 6);
        step(1, 0, 0);

        step(1, 0, 0);
        step(1, 0, 0);
        run_to_racing("cd_len3");
        repeat (7) step(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        check("rst_no_fin", int'(bus.finish_pulse), 0);
        check("rst_hold", int'(bus.state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3000)
          step(1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 7) == 0));
      end
      begin : sat_seq
        int n = 0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          bus2.start_pulse = 1'b1;
          @(negedge clk);
          bus2.start_pulse = 1'b0;
        end
        while (int'(bus2.state) != 4 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("sat_racing", int'(bus2.state), 4);
        check("sat_start", int'(bus2.race_ticks), 0);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_below", int'(bus2.race_ticks), 65534);
        repeat (70000 - 65534) @(posedge clk);
        #1;
        check("sat_top", int'(bus2.race_ticks), 65535);
        check("sat_state", int'(bus2.state), 4);
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
